// File: rtl/dm_access_if.sv
// Request/response handshakes and data-memory port of the load/store access controller.
// The slave modport is the controller; the master modport is the execute stage,
// the writeback consumer and the memory together.
interface dm_access_if #(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [TAG_W-1:0]  req_tag;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic [TAG_W-1:0]  resp_tag;
    logic              resp_err;

    logic [31:0]       dm_addr;
    logic              dm_read;
    logic              dm_write;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, req_tag,
        output req_ready,
        output resp_valid, resp_data, resp_tag, resp_err,
        input  resp_ready,
        output dm_addr, dm_read, dm_write, dm_wdata,
        input  dm_rdata
    );

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, req_tag,
        input  req_ready,
        input  resp_valid, resp_data, resp_tag, resp_err,
        output resp_ready,
        input  dm_addr, dm_read, dm_write, dm_wdata,
        output dm_rdata
    );
endinterface

// File: rtl/dm_access_ctrl.sv
// Load/store access controller in front of the data memory. Accepts one request at a
// time, sequences memory read/write strobes (read-modify-write for sub-word stores)
// and returns aligned, extended load data with the request tag.
//
// state | meaning
// IDLE  | ready for a request
// READ  | memory read strobe active, word captured into the buffer at the closing edge
// WRITE | memory write strobe active with full or lane-merged data
// RESP  | response presented, held until the consumer accepts it
module dm_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    dm_access_if.slave  bus
);
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t            state_q, state_d;
    logic              store_q, store_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [31:0]       buf_q, buf_d;
    logic              err_q, err_d;

    logic              req_err;
    logic [31:0]       merged;
    logic [31:0]       lane;
    logic [31:0]       ld_data;

    // Misaligned or illegal-size requests are answered without touching memory.
    assign req_err = (bus.req_size == 2'd3)
                   || ((bus.req_size == 2'd1) && bus.req_addr[0])
                   || ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));

    // State and latched request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            store_q    <= 1'b0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tag_q      <= '0;
            buf_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tag_q      <= tag_d;
            buf_q      <= buf_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic: latch on acceptance, capture read data at the end of READ.
    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tag_d      = tag_q;
        buf_d      = buf_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    store_d    = bus.req_store;
                    size_d     = bus.req_size;
                    unsigned_d = bus.req_unsigned;
                    addr_d     = bus.req_addr;
                    wdata_d    = bus.req_wdata;
                    tag_d      = bus.req_tag;
                    err_d      = req_err;
                    if (req_err)
                        state_d = RESP;
                    else if (bus.req_store && (bus.req_size == 2'd2))
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                buf_d   = bus.dm_rdata;
                state_d = store_q ? WRITE : RESP;
            end
            WRITE:   state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Store data: full word, or the buffered word with the addressed little-endian lane replaced.
    always_comb begin
        merged = buf_q;
        case (size_q)
            2'd0:    merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'd1:    merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Load data: shift the addressed lane down, then zero- or sign-extend.
    always_comb begin
        lane = buf_q >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'd0:    ld_data = {{24{~unsigned_q & lane[7]}}, lane[7:0]};
            2'd1:    ld_data = {{16{~unsigned_q & lane[15]}}, lane[15:0]};
            default: ld_data = lane;
        endcase
    end

    // req_ready is also gated by rst_n so nothing is accepted while reset is held.
    assign bus.req_ready  = rst_n && (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_data  = ((state_q == RESP) && !store_q && !err_q) ? ld_data : 32'd0;
    assign bus.resp_tag   = tag_q;
    assign bus.resp_err   = (state_q == RESP) && err_q;
    assign bus.dm_read    = (state_q == READ)  ? ENABLE : DISABLE;
    assign bus.dm_write   = (state_q == WRITE) ? ENABLE : DISABLE;
    assign bus.dm_addr    = ((state_q == READ) || (state_q == WRITE)) ? 32'(addr_q[ADDR_W-1:2]) : 32'd0;
    assign bus.dm_wdata   = (state_q == WRITE) ? merged : 32'd0;
endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: a small word memory model answers the memory port,
// expected responses go into a queue as requests are issued and are popped when the
// response appears.
module tb_dm_access_ctrl;
    logic clk;
    logic rst_n;

    dm_access_if #(.ADDR_W(32), .TAG_W(5)) bus ();

    dm_access_ctrl #(.ADDR_W(32), .TAG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:15];
    int rd_cyc = 0, wr_cyc = 0, both_cyc = 0;
    logic [31:0] last_wdata = '0, last_waddr = '0;

    assign bus.dm_rdata = bus.dm_read ? mem[bus.dm_addr[3:0]] : 32'hz;

    always @(posedge clk) begin
        if (bus.dm_read)  rd_cyc <= rd_cyc + 1;
        if (bus.dm_write) begin
            wr_cyc     <= wr_cyc + 1;
            last_wdata <= bus.dm_wdata;
            last_waddr <= bus.dm_addr;
            mem[bus.dm_addr[3:0]] <= bus.dm_wdata;
        end
        if (bus.dm_read && bus.dm_write) both_cyc <= both_cyc + 1;
    end

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int rd0, wr0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send(input bit st, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] tag,
                        input logic [31:0] exp_data, input bit exp_err, input int exp_lat,
                        input bit push);
        exp_t e;
        int n;
        @(negedge clk);
        bus.req_store    = st;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_tag      = tag;
        bus.req_valid    = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", 32'(n < 20), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'hDEAD_DEAD;
        if (push) begin
            e.data = exp_data;
            e.tag  = tag;
            e.err  = exp_err;
            e.lat  = exp_lat;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_resp(input string name, input int stall);
        exp_t e;
        int lat;
        lat = 1;
        @(negedge clk);
        while (!bus.resp_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        check("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({name, "_latency"}, 32'(lat), 32'(e.lat));
            check({name, "_data"}, bus.resp_data, e.data);
            check({name, "_tag"}, 32'(bus.resp_tag), 32'(e.tag));
            check({name, "_err"}, 32'(bus.resp_err), 32'(e.err));
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check({name, "_stall_valid"}, 32'(bus.resp_valid), 32'd1);
                check({name, "_stall_data"}, bus.resp_data, e.data);
                check({name, "_stall_tag"}, 32'(bus.resp_tag), 32'(e.tag));
                check({name, "_stall_req_ready"}, 32'(bus.req_ready), 32'd0);
            end
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        check({name, "_valid_drop"}, 32'(bus.resp_valid), 32'd0);
        check({name, "_ready_back"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req_ready"},  32'(bus.req_ready), 32'd0);
        check({name, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({name, "_resp_data"},  bus.resp_data, 32'd0);
        check({name, "_resp_tag"},   32'(bus.resp_tag), 32'd0);
        check({name, "_resp_err"},   32'(bus.resp_err), 32'd0);
        check({name, "_dm_addr"},    bus.dm_addr, 32'd0);
        check({name, "_dm_read"},    32'(bus.dm_read), 32'd0);
        check({name, "_dm_write"},   32'(bus.dm_write), 32'd0);
        check({name, "_dm_wdata"},   bus.dm_wdata, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0101_0101 * i;
        mem[0] = 32'h5555_5555;
        mem[3] = 32'h8899_AABB;
        mem[4] = 32'h1122_3344;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_tag = '0;
        bus.resp_ready = 1'b0;
        #13;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(bus.req_ready), 32'd1);

        rd0 = rd_cyc; wr0 = wr_cyc;
        send(0, 2'd0, 0, 32'h0D, 32'h0, 5'd1, 32'hFFFF_FFAA, 0, 2, 1);
        wait_resp("lb_signed", 0);
        check("lb_reads", 32'(rd_cyc - rd0), 32'd1);
        check("lb_writes", 32'(wr_cyc - wr0), 32'd0);

        send(0, 2'd0, 1, 32'h0D, 32'h0, 5'd2, 32'h0000_00AA, 0, 2, 1);
        wait_resp("lb_unsigned", 0);

        rd0 = rd_cyc; wr0 = wr_cyc;
        send(1, 2'd1, 0, 32'h0E, 32'h0000_1234, 5'd3, 32'h0, 0, 3, 1);
        wait_resp("sh_store", 0);
        check("sh_reads", 32'(rd_cyc - rd0), 32'd1);
        check("sh_writes", 32'(wr_cyc - wr0), 32'd1);
        check("sh_wdata", last_wdata, 32'h1234_AABB);
        check("sh_waddr", last_waddr, 32'd3);

        send(0, 2'd2, 0, 32'h0C, 32'h0, 5'd4, 32'h1234_AABB, 0, 2, 1);
        wait_resp("lw_after_sh", 0);

        rd0 = rd_cyc; wr0 = wr_cyc;
        send(1, 2'd2, 0, 32'h00, 32'hAAAA_AAAA, 5'd5, 32'h0, 0, 2, 1);
        wait_resp("sw_store", 0);
        check("sw_reads", 32'(rd_cyc - rd0), 32'd0);
        check("sw_writes", 32'(wr_cyc - wr0), 32'd1);
        check("sw_waddr", last_waddr, 32'd0);
        send(0, 2'd2, 0, 32'h00, 32'h0, 5'd6, 32'hAAAA_AAAA, 0, 2, 1);
        wait_resp("lw_after_sw", 0);

        rd0 = rd_cyc; wr0 = wr_cyc;
        send(0, 2'd2, 0, 32'h0E, 32'h0, 5'd7, 32'h0, 1, 1, 1);
        wait_resp("lw_misaligned", 0);
        send(0, 2'd3, 0, 32'h00, 32'h0, 5'd8, 32'h0, 1, 1, 1);
        wait_resp("size3", 0);
        send(1, 2'd1, 0, 32'h05, 32'h0000_FFFF, 5'd9, 32'h0, 1, 1, 1);
        wait_resp("sh_misaligned", 0);
        check("err_reads", 32'(rd_cyc - rd0), 32'd0);
        check("err_writes", 32'(wr_cyc - wr0), 32'd0);

        send(0, 2'd1, 0, 32'h0E, 32'h0, 5'd10, 32'h0000_1234, 0, 2, 1);
        wait_resp("lh_upper", 0);
        send(0, 2'd1, 0, 32'h0C, 32'h0, 5'd11, 32'hFFFF_AABB, 0, 2, 1);
        wait_resp("lh_lower_signed", 0);
        send(1, 2'd0, 0, 32'h01, 32'h0000_005A, 5'd12, 32'h0, 0, 3, 1);
        wait_resp("sb_store", 0);
        check("sb_wdata", last_wdata, 32'hAAAA_5AAA);

        send(0, 2'd0, 0, 32'h01, 32'h0, 5'd13, 32'h0000_005A, 0, 2, 1);
        wait_resp("stall_load", 3);

        send(1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 5'd14, 32'h0, 0, 2, 0);
        check("rst_mid_in_write", 32'(bus.dm_write), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        @(negedge clk);
        check("mid_reset_mem4", mem[4], 32'h1122_3344);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        check("mem4_untouched", mem[4], 32'h1122_3344);
        check("never_both_strobes", 32'(both_cyc), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Load/store access controller sitting directly upstream of the data memory `M`. It accepts one load or store request at a time from the execute stage over a valid/ready handshake and converts byte addresses to word addresses. It sequences `M`'s `read`/`write` strobes, performing read-modify-write for sub-word stores. Each load is aligned and sign- or zero-extended before being returned to writeback over a second valid/ready handshake.

## Interface
- ADDR_W, 32, byte-address width; memory word address = addr[ADDR_W-1:2], zero-extended to 32 bits.
- TAG_W, 5, destination-register tag width, returned unchanged with the response.
- clk  in  1  rising-edge clock shared with `M`.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; 1 only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and raises an error.
- req_unsigned  in  1  load zero-extend (1) or sign-extend (0).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; sub-word data in the low bits.
- req_tag  in  TAG_W  opaque tag.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  32  extended load data; 0 for stores and errors.
- resp_tag  out  TAG_W  tag of the completed request.
- resp_err  out  1  misaligned or illegal-size request; memory is not touched.
- dm_addr  out  32  word address to `M`.
- dm_read  out  1  `M` read strobe (ENABLE/DISABLE).
- dm_write  out  1  `M` write strobe (ENABLE/DISABLE).
- dm_wdata  out  32  `M` write data.
- dm_rdata  in  32  `M` read data; valid combinationally while dm_read = ENABLE; high-Z otherwise and never sampled then.

## Operation
- FSM states: IDLE, READ, WRITE, RESP. The request fields are latched on the handshake.
- IDLE -> RESP with resp_err = 1 when the request is misaligned or req_size = 3. Misaligned means half with addr[0] = 1, or word with addr[1:0] ≠ 0.
- IDLE -> READ for a load or a sub-word store; IDLE -> WRITE for a word store.
- READ: dm_read = ENABLE; dm_rdata is captured into the data buffer at the closing edge. READ -> RESP for a load; READ -> WRITE for a store.
- WRITE: dm_write = ENABLE. dm_wdata is the word store data, or the buffered word with the addressed lane replaced.
  - Lanes are little-endian: byte lane addr[1:0] occupies bits [8·lane+7 : 8·lane]; half lane addr[1] occupies bits [16·addr[1]+15 : 16·addr[1]].
  - WRITE -> RESP.
- RESP: resp_valid = 1; outputs are held stable until resp_ready = 1, then the FSM returns to IDLE.
- Load result: the addressed lane is extracted, then zero- or sign-extended to 32 bits per req_unsigned.
- dm_read and dm_write are never ENABLE in the same cycle. Both are DISABLE in IDLE and RESP. dm_wdata = 0 when not writing.

## Timing
- Reset (asynchronous assertion) forces state = IDLE, with req_ready = 0 while rst_n = 0 and resp_valid = 0. resp_data, resp_tag, resp_err, dm_addr and dm_wdata reset to 0; dm_read and dm_write reset to DISABLE.
- Taking the handshake edge as T, resp_valid first rises at:
  - load: T+2;
  - word store: T+2;
  - sub-word store: T+3;
  - error: T+1.
- Next acceptance happens no earlier than the edge after the response handshake; there is no request/response overlap.
- Reset mid-operation abandons the request with no response. A WRITE cycle interrupted before its closing edge leaves memory unmodified.
- req_* inputs are ignored outside IDLE. A resp_ready held low stalls the FSM indefinitely.

## Test plan
- Preload word 3 = 0x8899AABB. Signed byte load at 0x0D -> resp_data = 0xFFFFFFAA at T+2; the same load with req_unsigned = 1 -> 0x000000AA.
- Half store 0x1234 at 0x0E -> one READ cycle, then one WRITE cycle with dm_wdata = 0x1234AABB. A following word load at 0x0C returns 0x1234AABB.
- Word store 0xAAAAAAAA at 0x00 -> single WRITE cycle with dm_addr = 0 and no READ cycle. A following load returns 0xAAAAAAAA; dm_read and dm_write are never both ENABLE.
- Word load at 0x0E -> resp_err = 1 at T+1 and resp_data = 0. dm_read and dm_write stay DISABLE throughout.
- Hold resp_ready = 0 for 3 cycles after resp_valid rises -> resp_data and resp_tag are stable and req_ready = 0. The next request is accepted only after the handshake.
- Assert rst_n = 0 during the WRITE cycle of a store to 0x10 -> outputs return to reset values immediately and no response is issued. Word 4 still holds its old value.
